rx_frame_dec: RTL and testbench

Parametrised successor to the fixed 4-byte command decoder in the control_top receive path. It sits between the byte-level receiver and the command dispatcher. It hunts for a header byte, collects NBYTE payload bytes into a flat word, and optionally checks a trailing checksum. Timeout is inter-byte and programmable; good and bad frames are counted.

---
 rtl/rx_frame_dec_if.sv | 31 +++
 rtl/rx_frame_dec.sv | 197 +++++++++++++++++++
 tb/tb_rx_frame_dec.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/rx_frame_dec_if.sv
// rx_frame_dec_if -- byte-receive and decoded-frame bundle for rx_frame_dec.
//   master : the side that supplies bytes and consumes frames (dispatcher side)
//   slave  : the decoder itself
//   rx_vld/rx_data        one-cycle byte strobe and byte
//   frm_data/frm_vld      decoded payload and its one-cycle update pulse
//   frm_err/err_code      one-cycle abort pulse and its cause
//   cnt_ok/cnt_err        saturating good/aborted frame counters
`timescale 1ns/1ps
interface rx_frame_dec_if #(
  parameter int NBYTE  = 4,
  parameter int STAT_W = 16
);
  logic                 rx_vld;
  logic [7:0]           rx_data;
  logic [NBYTE*8-1:0]   frm_data;
  logic                 frm_vld;
  logic                 frm_err;
  logic [1:0]           err_code;
  logic [STAT_W-1:0]    cnt_ok;
  logic [STAT_W-1:0]    cnt_err;

  modport master (
    output rx_vld, rx_data,
    input  frm_data, frm_vld, frm_err, err_code, cnt_ok, cnt_err
  );

  modport slave (
    input  rx_vld, rx_data,
    output frm_data, frm_vld, frm_err, err_code, cnt_ok, cnt_err
  );
endinterface

// File: rtl/rx_frame_dec.sv
// rx_frame_dec -- hunts for a header byte, gathers NBYTE payload bytes into a
// flat word (first byte in the top bits) and reports good/aborted frames.
// Optional trailing checksum (8-bit sum of the payload) is compiled in with
// the macro RX_FRAME_CHKSUM_EN; without it the last payload byte completes
// the frame.
// Ports:
//   clk_sys  system clock
//   rst      synchronous, active-high reset
//   bus      rx_frame_dec_if.slave (rx_vld, rx_data in; frm_data, frm_vld,
//            frm_err, err_code, cnt_ok, cnt_err out; all outputs registered)
// err_code: 2'b01 inter-byte timeout, 2'b10 checksum mismatch.
`timescale 1ns/1ps
module rx_frame_dec #(
  parameter int         NBYTE   = 4,
  parameter logic [7:0] HDR     = 8'hA5,
  parameter int         TIMEOUT = 100000,
  parameter int         CNT_W   = 20,
  parameter int         STAT_W  = 16
) (
  input  logic           clk_sys,
  input  logic           rst,
  rx_frame_dec_if.slave  bus
);

  localparam int                IDX_W    = (NBYTE > 1) ? $clog2(NBYTE) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NBYTE - 1);
  localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [STAT_W-1:0] CNT_MAX  = {STAT_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PAY  = 3'd1,
`ifdef RX_FRAME_CHKSUM_EN
    S_CHK  = 3'd2,
`endif
    S_DONE = 3'd3,
    S_FAIL = 3'd4
  } state_t;

  state_t               state_r, state_nxt_s;
  logic [IDX_W-1:0]     idx_r, idx_nxt_s;
  logic [CNT_W-1:0]     tmr_r, tmr_nxt_s;
  logic [NBYTE*8-1:0]   shadow_r, shadow_nxt_s;
  logic [1:0]           err_code_nxt_s;
`ifdef RX_FRAME_CHKSUM_EN
  logic [7:0]           sum_r, sum_nxt_s;
`endif

  logic [NBYTE*8-1:0]   frm_data_r;
  logic                 frm_vld_r;
  logic                 frm_err_r;
  logic [1:0]           err_code_r;
  logic [STAT_W-1:0]    cnt_ok_r;
  logic [STAT_W-1:0]    cnt_err_r;

  // State register.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and datapath update decode.
  always_comb begin
    state_nxt_s    = state_r;
    idx_nxt_s      = idx_r;
    tmr_nxt_s      = tmr_r;
    shadow_nxt_s   = shadow_r;
    err_code_nxt_s = 2'b00;
`ifdef RX_FRAME_CHKSUM_EN
    sum_nxt_s      = sum_r;
`endif
    case (state_r)
      S_IDLE: begin
        if (bus.rx_vld && (bus.rx_data == HDR)) begin
          state_nxt_s = S_PAY;
          idx_nxt_s   = {IDX_W{1'b0}};
          tmr_nxt_s   = {CNT_W{1'b0}};
`ifdef RX_FRAME_CHKSUM_EN
          sum_nxt_s   = 8'h00;
`endif
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_PAY: begin
        // A header value here is ordinary payload; a byte always beats expiry.
        if (bus.rx_vld) begin
          shadow_nxt_s = {shadow_r[NBYTE*8-9:0], bus.rx_data};
          idx_nxt_s    = idx_r + IDX_W'(1);
          tmr_nxt_s    = {CNT_W{1'b0}};
`ifdef RX_FRAME_CHKSUM_EN
          sum_nxt_s    = sum_r + bus.rx_data;
`endif
          if (idx_r == IDX_LAST) begin
`ifdef RX_FRAME_CHKSUM_EN
            state_nxt_s = S_CHK;
`else
            state_nxt_s = S_DONE;
`endif
          end else begin
            state_nxt_s = S_PAY;
          end
        end else if (tmr_r == TMO_LAST) begin
          state_nxt_s    = S_FAIL;
          err_code_nxt_s = 2'b01;
        end else begin
          tmr_nxt_s = tmr_r + CNT_W'(1);
        end
      end
`ifdef RX_FRAME_CHKSUM_EN
      S_CHK: begin
        if (bus.rx_vld) begin
          tmr_nxt_s = {CNT_W{1'b0}};
          if (bus.rx_data == sum_r) begin
            state_nxt_s = S_DONE;
          end else begin
            state_nxt_s    = S_FAIL;
            err_code_nxt_s = 2'b10;
          end
        end else if (tmr_r == TMO_LAST) begin
          state_nxt_s    = S_FAIL;
          err_code_nxt_s = 2'b01;
        end else begin
          tmr_nxt_s = tmr_r + CNT_W'(1);
        end
      end
`endif
      // Bytes arriving here are dropped, including a header.
      S_DONE:  state_nxt_s = S_IDLE;
      S_FAIL:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Frame-collection datapath registers.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      idx_r    <= {IDX_W{1'b0}};
      tmr_r    <= {CNT_W{1'b0}};
      shadow_r <= {(NBYTE*8){1'b0}};
`ifdef RX_FRAME_CHKSUM_EN
      sum_r    <= 8'h00;
`endif
    end else begin
      idx_r    <= idx_nxt_s;
      tmr_r    <= tmr_nxt_s;
      shadow_r <= shadow_nxt_s;
`ifdef RX_FRAME_CHKSUM_EN
      sum_r    <= sum_nxt_s;
`endif
    end
  end

  // Output registers, loaded on entry to S_DONE/S_FAIL so the pulses line up
  // with those states (the cycle after the deciding byte or expiry).
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      frm_data_r <= {(NBYTE*8){1'b0}};
      frm_vld_r  <= 1'b0;
      frm_err_r  <= 1'b0;
      err_code_r <= 2'b00;
      cnt_ok_r   <= {STAT_W{1'b0}};
      cnt_err_r  <= {STAT_W{1'b0}};
    end else begin
      frm_vld_r  <= (state_nxt_s == S_DONE);
      frm_err_r  <= (state_nxt_s == S_FAIL);
      err_code_r <= err_code_nxt_s;
      if (state_nxt_s == S_DONE) begin
        frm_data_r <= shadow_nxt_s;
        if (cnt_ok_r != CNT_MAX) begin
          cnt_ok_r <= cnt_ok_r + STAT_W'(1);
        end else begin
          cnt_ok_r <= cnt_ok_r;
        end
      end else begin
        frm_data_r <= frm_data_r;
        cnt_ok_r   <= cnt_ok_r;
      end
      if ((state_nxt_s == S_FAIL) && (cnt_err_r != CNT_MAX)) begin
        cnt_err_r <= cnt_err_r + STAT_W'(1);
      end else begin
        cnt_err_r <= cnt_err_r;
      end
    end
  end

  assign bus.frm_data = frm_data_r;
  assign bus.frm_vld  = frm_vld_r;
  assign bus.frm_err  = frm_err_r;
  assign bus.err_code = err_code_r;
  assign bus.cnt_ok   = cnt_ok_r;
  assign bus.cnt_err  = cnt_err_r;

endmodule

// File: tb/tb_rx_frame_dec.sv
// tb_rx_frame_dec -- directed bench for rx_frame_dec (NBYTE=4, HDR=A5,
// TIMEOUT=50, STAT_W=2). Works with or without RX_FRAME_CHKSUM_EN.
`timescale 1ns/1ps
module tb_rx_frame_dec;

  logic clk_sys = 1'b0;
  logic rst     = 1'b1;

  rx_frame_dec_if #(.NBYTE(4), .STAT_W(2)) bus ();

  rx_frame_dec #(
    .NBYTE(4), .HDR(8'hA5), .TIMEOUT(50), .CNT_W(20), .STAT_W(2)
  ) dut (
    .clk_sys (clk_sys),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  int n_vec  = 0;
  int n_miss = 0;
  int vld_seen = 0;
  int err_seen = 0;

  // Pulse monitor, sampled away from the active edge.
  always @(negedge clk_sys) begin
    if (bus.frm_vld) vld_seen = vld_seen + 1;
    if (bus.frm_err) err_seen = err_seen + 1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_vld  = 1'b1;
    bus.rx_data = b;
    @(posedge clk_sys);
    #1;
    bus.rx_vld  = 1'b0;
    bus.rx_data = 8'h00;
  endtask

  // Header, 4 payload bytes and (if compiled in) checksum, gap idle cycles between bytes.
  task automatic send_frame(input logic [31:0] pay, input int gap, input logic bad_chk);
    logic [7:0] s;
    s = 8'h00;
    send_byte(8'hA5);
    for (int i = 0; i < 4; i++) begin
      tick(gap);
      send_byte(pay[31-8*i -: 8]);
      s = s + pay[31-8*i -: 8];
    end
`ifdef RX_FRAME_CHKSUM_EN
    tick(gap);
    send_byte(bad_chk ? ~s : s);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    vld_seen = 0;
    err_seen = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (bus.frm_data !== 32'h0) begin n_miss++; $display("FAIL rst_data: got %h exp %h", bus.frm_data, 32'h0); end
    n_vec++; if ({bus.frm_vld, bus.frm_err, bus.err_code} !== 4'b0000) begin n_miss++; $display("FAIL rst_flags: got %b exp 0000", {bus.frm_vld, bus.frm_err, bus.err_code}); end
    n_vec++; if ({bus.cnt_ok, bus.cnt_err} !== 4'b0000) begin n_miss++; $display("FAIL rst_cnt: got %b exp 0000", {bus.cnt_ok, bus.cnt_err}); end
  endtask

  task automatic test_good_frame();
    do_reset();
    send_frame(32'h11223344, 9, 1'b0);
    n_vec++; if (bus.frm_vld !== 1'b1) begin n_miss++; $display("FAIL good_vld: got %b exp 1", bus.frm_vld); end
    n_vec++; if (bus.frm_data !== 32'h11223344) begin n_miss++; $display("FAIL good_data: got %h exp %h", bus.frm_data, 32'h11223344); end
    n_vec++; if (bus.cnt_ok !== 2'd1) begin n_miss++; $display("FAIL good_cnt: got %0d exp 1", bus.cnt_ok); end
    tick(1);
    n_vec++; if (bus.frm_vld !== 1'b0) begin n_miss++; $display("FAIL good_vld_len: got %b exp 0", bus.frm_vld); end
    n_vec++; if (err_seen !== 0) begin n_miss++; $display("FAIL good_noerr: got %0d exp 0", err_seen); end
  endtask

  task automatic test_bad_chk();
`ifdef RX_FRAME_CHKSUM_EN
    do_reset();
    send_frame(32'h11223344, 0, 1'b0);
    tick(2);
    send_frame(32'h01020304, 0, 1'b1);
    n_vec++; if ({bus.frm_err, bus.err_code} !== 3'b110) begin n_miss++; $display("FAIL chk_err: got %b exp 110", {bus.frm_err, bus.err_code}); end
    n_vec++; if (bus.frm_data !== 32'h11223344) begin n_miss++; $display("FAIL chk_keep: got %h exp %h", bus.frm_data, 32'h11223344); end
    n_vec++; if (bus.cnt_err !== 2'd1) begin n_miss++; $display("FAIL chk_cnt: got %0d exp 1", bus.cnt_err); end
    tick(1);
    n_vec++; if ({bus.frm_err, bus.err_code} !== 3'b000) begin n_miss++; $display("FAIL chk_clear: got %b exp 000", {bus.frm_err, bus.err_code}); end
`endif
  endtask

  task automatic test_timeout();
    int early;
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h01);
    early = 0;
    for (int i = 0; i < 49; i++) begin
      tick(1);
      if (bus.frm_err) early++;
    end
    n_vec++; if (early !== 0) begin n_miss++; $display("FAIL tmo_early: got %0d exp 0", early); end
    tick(1);
    n_vec++; if ({bus.frm_err, bus.err_code} !== 3'b101) begin n_miss++; $display("FAIL tmo_err: got %b exp 101", {bus.frm_err, bus.err_code}); end
    n_vec++; if (bus.cnt_err !== 2'd1) begin n_miss++; $display("FAIL tmo_cnt: got %0d exp 1", bus.cnt_err); end
    tick(1);
    n_vec++; if ({bus.frm_err, bus.err_code} !== 3'b000) begin n_miss++; $display("FAIL tmo_clear: got %b exp 000", {bus.frm_err, bus.err_code}); end
    // Bytes on the 49th idle cycle and exactly at expiry both keep the frame alive.
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h01);
    tick(48);
    send_byte(8'h02);
    tick(49);
    send_byte(8'h03);
    send_byte(8'h04);
`ifdef RX_FRAME_CHKSUM_EN
    send_byte(8'h0A);
`endif
    n_vec++; if (bus.frm_vld !== 1'b1 || bus.frm_data !== 32'h01020304) begin n_miss++; $display("FAIL tmo_edge: got vld %b data %h exp 1 %h", bus.frm_vld, bus.frm_data, 32'h01020304); end
    n_vec++; if (err_seen !== 0) begin n_miss++; $display("FAIL tmo_edge_noerr: got %0d exp 0", err_seen); end
  endtask

  task automatic test_resync();
    do_reset();
    send_byte(8'h00); tick(1);
    send_byte(8'hFF); tick(1);
    send_byte(8'h3C); tick(1);
    send_frame(32'hA5A5A5A5, 0, 1'b0);
    n_vec++; if (bus.frm_data !== 32'hA5A5A5A5) begin n_miss++; $display("FAIL resync_data: got %h exp %h", bus.frm_data, 32'hA5A5A5A5); end
    n_vec++; if (bus.cnt_ok !== 2'd1 || err_seen !== 0) begin n_miss++; $display("FAIL resync_cnt: got ok %0d errs %0d exp 1 0", bus.cnt_ok, err_seen); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_frame(32'h11223344, 0, 1'b0);
    tick(1);
    send_byte(8'hA5);
    send_byte(8'h11);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    vld_seen = 0;
    err_seen = 0;
    n_vec++; if (bus.frm_data !== 32'h0 || bus.cnt_ok !== 2'd0) begin n_miss++; $display("FAIL rmid_clear: got data %h ok %0d exp 0 0", bus.frm_data, bus.cnt_ok); end
    tick(60);
    n_vec++; if (err_seen !== 0 || vld_seen !== 0) begin n_miss++; $display("FAIL rmid_nopulse: got errs %0d vlds %0d exp 0 0", err_seen, vld_seen); end
    send_frame(32'hCAFEBABE, 2, 1'b0);
    n_vec++; if (bus.frm_vld !== 1'b1 || bus.frm_data !== 32'hCAFEBABE || bus.cnt_ok !== 2'd1) begin n_miss++; $display("FAIL rmid_after: got vld %b data %h ok %0d exp 1 %h 1", bus.frm_vld, bus.frm_data, bus.cnt_ok, 32'hCAFEBABE); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send_frame(32'h10000000 + 32'(i), 0, 1'b0);
      tick(1);
      if (i == 2) begin
        n_vec++; if (bus.cnt_ok !== 2'd3) begin n_miss++; $display("FAIL sat_ok3: got %0d exp 3", bus.cnt_ok); end
      end
    end
    n_vec++; if (bus.cnt_ok !== 2'd3 || vld_seen !== 5) begin n_miss++; $display("FAIL sat_ok: got ok %0d vlds %0d exp 3 5", bus.cnt_ok, vld_seen); end
    n_vec++; if (bus.frm_data !== 32'h10000004) begin n_miss++; $display("FAIL sat_data: got %h exp %h", bus.frm_data, 32'h10000004); end
    for (int i = 0; i < 4; i++) begin
      send_byte(8'hA5);
      tick(60);
    end
    n_vec++; if (bus.cnt_err !== 2'd3 || err_seen !== 4) begin n_miss++; $display("FAIL sat_err: got cnt %0d errs %0d exp 3 4", bus.cnt_err, err_seen); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_frame(32'h10203040, 0, 1'b0);
    // Header lands in the S_DONE cycle and is lost; the rest is garbage in idle.
    send_byte(8'hA5);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
`ifdef RX_FRAME_CHKSUM_EN
    send_byte(8'h0A);
`endif
    tick(2);
    n_vec++; if (bus.cnt_ok !== 2'd1 || vld_seen !== 1 || bus.frm_data !== 32'h10203040) begin n_miss++; $display("FAIL b2b_drop: got ok %0d vlds %0d data %h exp 1 1 %h", bus.cnt_ok, vld_seen, bus.frm_data, 32'h10203040); end
    send_frame(32'h05060708, 0, 1'b0);
    tick(1);
    send_frame(32'h090A0B0C, 0, 1'b0);
    n_vec++; if (bus.frm_data !== 32'h090A0B0C || bus.cnt_ok !== 2'd3 || err_seen !== 0) begin n_miss++; $display("FAIL b2b_next: got data %h ok %0d errs %0d exp %h 3 0", bus.frm_data, bus.cnt_ok, err_seen, 32'h090A0B0C); end
  endtask

  initial begin
    bus.rx_vld  = 1'b0;
    bus.rx_data = 8'h00;
    @(posedge clk_sys);
    #1;
    test_reset();
    test_good_frame();
    test_bad_chk();
    test_timeout();
    test_resync();
    test_reset_mid();
    test_saturation();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
